// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: loads pattern/length/overlap/threshold via
// valid/ready, then scans a qualified bit stream with a Mealy match pulse and match counter.
module seq_detect_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int LENW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_threshold,
    input  logic              start,
    input  logic              stop,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              match,
    output logic [CNTW-1:0]   match_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

    localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [MAXLEN-1:0] hist_q, hist_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   fill_q, fill_d;
    logic              overlap_q, overlap_d;
    logic [CNTW-1:0]   thr_q, thr_d;
    logic [CNTW-1:0]   count_q, count_d;

    logic [LENW-1:0]   len_clamped;
    logic [CNTW-1:0]   count_inc;
    logic [MAXLEN-1:0] candidate;
    logic [MAXLEN-1:0] len_mask;
    logic              cfg_accept;
    logic              fill_ok;
    logic              pattern_hit;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LENW'(1);
        end else if (cfg_len > MAXLEN_L) begin
            len_clamped = MAXLEN_L;
        end
    end

    // Only the low len bits of the candidate take part in the comparison.
    generate
        for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
            assign len_mask[gi] = (LENW'(gi) < len_q);
        end
    endgenerate

    assign candidate   = {hist_q[MAXLEN-2:0], bit_in};
    assign fill_ok     = ({1'b0, fill_q} + {{LENW{1'b0}}, 1'b1}) >= {1'b0, len_q};
    assign pattern_hit = ((candidate ^ pattern_q) & len_mask) == '0;
    assign match       = (state_q == S_ARMED) && bit_valid && !stop && fill_ok && pattern_hit;
    assign count_inc   = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign cfg_accept  = cfg_valid && (state_q != S_ARMED);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hist_d    = hist_q;
        len_d     = len_q;
        fill_d    = fill_q;
        overlap_d = overlap_q;
        thr_d     = thr_q;
        count_d   = count_q;

        if (cfg_accept) begin
            pattern_d = cfg_pattern;
            len_d     = len_clamped;
            overlap_d = cfg_overlap;
            thr_d     = cfg_threshold;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARMED;
                    count_d = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            S_ARMED: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (bit_valid) begin
                    hist_d = candidate;
                    fill_d = (fill_q == MAXLEN_L) ? fill_q : fill_q + 1'b1;
                    if (match) begin
                        count_d = count_inc;
                        // Non-overlapping mode forgets every bit consumed by this match.
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                        if ((thr_q != '0) && (count_inc == thr_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_ARMED;
                    count_d = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            hist_q    <= '0;
            len_q     <= LENW'(1);
            fill_q    <= '0;
            overlap_q <= 1'b0;
            thr_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            overlap_q <= overlap_d;
            thr_q     <= thr_d;
            count_q   <= count_d;
        end
    end

    assign cfg_ready   = (state_q != S_ARMED);
    assign busy        = (state_q == S_ARMED);
    assign done        = (state_q == S_DONE);
    assign match_count = count_q;

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run-time programmable serial pattern-detection controller for the FSM sequence-detector family. It replaces hard-coded Mealy detectors such as the 10011 detector with one configurable block. Software or a test sequencer loads a pattern (1..MAXLEN bits), an overlap mode and a match threshold through a valid/ready handshake, then arms the block. The block scans a qualified serial bit stream, emits a Mealy-style match pulse, counts matches and flags completion when the threshold is reached.

## Interface
- MAXLEN, 8: maximum pattern length in bits (2..16).
- CNTW, 8: width of the match counter and the threshold.
- LENW, 4: width of cfg_len; must hold MAXLEN.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high in IDLE and DONE; config accepted when cfg_valid && cfg_ready.
- cfg_pattern  in  MAXLEN  pattern; bit cfg_len-1 is received first, bit 0 last.
- cfg_len  in  LENW  pattern length; 0 clamps to 1, values above MAXLEN clamp to MAXLEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_threshold  in  CNTW  match count that ends the run; 0 = free-run, never done.
- start  in  1  arm pulse.
- stop  in  1  disarm pulse.
- bit_valid  in  1  bit_in is qualified this cycle.
- bit_in  in  1  serial data.
- match  out  1  combinational pulse in the cycle the final pattern bit is presented.
- match_count  out  CNTW  matches since the last start; saturates at all-ones.
- busy  out  1  high in ARMED.
- done  out  1  high in DONE.

## Operation
- States: IDLE, ARMED, DONE. All outputs except match are registered.
- Reset:
  - state = IDLE, match_count = 0, busy = 0, done = 0, match = 0, cfg_ready = 1.
  - Config registers reset to pattern 0, len 1, overlap 0, threshold 0.
  - History shift register and fill counter reset to 0.
- Config: accepted in IDLE or DONE on cfg_valid && cfg_ready. Latched on that edge. In ARMED, cfg_ready = 0 and cfg_valid is ignored.
- IDLE:
  - start -> ARMED. Clears match_count, history and fill.
  - If cfg is accepted in the same cycle, the new config is used by the run.
- ARMED: each cycle with bit_valid, the candidate is {history, bit_in}.
  - match = 1 when fill+1 >= len and the low len bits of the candidate equal the low len bits of the pattern.
  - History shifts bit_in in; fill increments and saturates at MAXLEN.
  - On match, match_count increments (saturating).
  - On match with overlap = 0, fill is cleared to 0 so no bit is reused.
  - On match with overlap = 1, fill continues.
- Threshold: if threshold != 0 and the post-increment count equals threshold -> DONE on that edge.
- Priority in ARMED: stop > bit processing. If stop is high:
  - -> IDLE, match_count is retained.
  - The bit in that cycle is dropped and match = 0.
  - A start in the same cycle is ignored.
- start while ARMED is ignored.
- DONE:
  - done = 1 and is held; bits are ignored and match = 0.
  - start -> ARMED with a fresh count; stop -> IDLE.
- match is gated to 0 whenever state != ARMED or bit_valid = 0.
- bit_valid = 0 cycles are transparent: no shift and no fill change.

## Timing
- match: zero latency, combinational from bit_valid/bit_in in ARMED.
- match_count: updates on the edge that ends the match cycle.
- done and busy: change on the edge that ends the cycle with the threshold-reaching match, start or stop.
- start -> busy = 1 on the next cycle. The first bit is sampled in the cycle after start.
- rst has priority over every input on the same edge, including mid-run. Outputs reach reset values on the next cycle.

## Test plan
- Reset mid-run: run ARMED with count 3, assert rst one cycle -> next cycle state IDLE, count 0, done 0, busy 0, cfg_ready 1.
- Overlap on:
  - Config pattern 8'b0001_0011, len 5, overlap 1, threshold 0; start; stream 1,0,0,1,1,0,0,1,1.
  - Expect match pulses on bits 5 and 9, and match_count = 2.
- Overlap off: same stream with overlap 0 -> a single match on bit 5, match_count = 1.
- Threshold and bubbles:
  - Pattern 2'b11, len 2, overlap 1, threshold 3; stream of six 1s with bit_valid gaps.
  - Expect matches on valid bits 2, 3 and 4, then done = 1 and busy = 0 on the next cycle.
  - Later bits give no match and the count stays at 3.
- Stop/start collision:
  - In ARMED, assert stop and start with bit_valid and a completing bit -> match = 0, next cycle IDLE, count retained.
  - A following start clears the count.
- Config gating and clamping:
  - cfg_valid in ARMED -> not accepted.
  - In IDLE, cfg_len 0 with pattern bit0 = 1 -> every valid 1 matches.
  - Count saturates at 255 after 300 matches.
